muldiv_seq: RTL and testbench

//  Multi-cycle sequencer for MIPS32 MULT/MULTU/DIV/DIVU. Time-shares one 32-bit add/sub

---
 rtl/muldiv_pkg.sv | 32 +++
 rtl/muldiv_if.sv | 28 ++
 rtl/muldiv_step.sv | 86 ++++++++
 rtl/muldiv_seq.sv | 171 +++++++++++++++++
 tb/tb_muldiv_seq.sv | 167 ++++++++++++++++
 5 files changed

// File: rtl/muldiv_pkg.sv
// Shared types and constants for the sequential MIPS32 multiply/divide unit.
package muldiv_pkg;

  localparam int unsigned WIDTH = 32;
  localparam int unsigned CNT_W = 6;
  localparam int unsigned ITERS = 32;
  localparam logic [WIDTH-1:0] DIV0_QUOT = '1;

  typedef enum logic [1:0] {
    OP_MULT  = 2'b00,
    OP_MULTU = 2'b01,
    OP_DIV   = 2'b10,
    OP_DIVU  = 2'b11
  } op_e;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_PREP_A,
    ST_PREP_B,
    ST_RUN,
    ST_FIX_LO,
    ST_FIX_HI,
    ST_DONE
  } state_e;

  typedef struct packed {
    op_e              op;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
  } req_t;

endpackage

// File: rtl/muldiv_if.sv
// Request / result handshake bundle between the EX stage and muldiv_seq.
interface muldiv_if;
  import muldiv_pkg::*;

  logic             start_valid_in;
  logic             start_ready_out;
  logic [1:0]       op_in;
  logic [WIDTH-1:0] a_in;
  logic [WIDTH-1:0] b_in;
  logic             flush_in;
  logic             done_valid_out;
  logic             done_ready_in;
  logic [WIDTH-1:0] hi_out;
  logic [WIDTH-1:0] lo_out;
  logic             div0_out;
  logic             busy_out;

  modport slave (
    input  start_valid_in, op_in, a_in, b_in, flush_in, done_ready_in,
    output start_ready_out, done_valid_out, hi_out, lo_out, div0_out, busy_out
  );

  modport master (
    output start_valid_in, op_in, a_in, b_in, flush_in, done_ready_in,
    input  start_ready_out, done_valid_out, hi_out, lo_out, div0_out, busy_out
  );

endinterface

// File: rtl/muldiv_step.sv
// One combinational multiply/divide iteration around the single shared add/sub unit.
module muldiv_step
  import muldiv_pkg::*;
(
  input  state_e           state,
  input  logic             is_div,
  input  logic [WIDTH-1:0] opnd,
  input  logic [WIDTH-1:0] mag_b,
  input  logic [WIDTH-1:0] acc_hi,
  input  logic [WIDTH-1:0] acc_lo,
  input  logic             neg_lo,
  input  logic             neg_hi,
  input  logic             fix_carry,
  output logic [WIDTH-1:0] sum_c,
  output logic             cout_c,
  output logic [WIDTH-1:0] nxt_hi_c,
  output logic [WIDTH-1:0] nxt_lo_c
);

  logic [WIDTH-1:0] x, y, rem_shift;
  logic             sub, cin, no_borrow;

  // Operand and mode selection per phase
  always_comb begin
    x         = '0;
    y         = '0;
    sub       = 1'b0;
    cin       = 1'b0;
    rem_shift = {acc_hi[WIDTH-2:0], acc_lo[WIDTH-1]};
    case (state)
      ST_PREP_A, ST_PREP_B: begin
        sub = 1'b1;
        y   = opnd;
      end
      ST_RUN: begin
        if (is_div) begin
          x   = rem_shift;
          y   = mag_b;
          sub = 1'b1;
        end else begin
          x = acc_hi;
          y = acc_lo[0] ? mag_b : '0;
        end
      end
      ST_FIX_LO: begin
        sub = 1'b1;
        y   = acc_lo;
      end
      ST_FIX_HI: begin
        if (is_div) begin
          sub = 1'b1;
          y   = acc_hi;
        end else begin
          x   = ~acc_hi;
          cin = fix_carry;
        end
      end
      default: ;
    endcase
  end

  assign {cout_c, sum_c} = {1'b0, x} + {1'b0, (sub ? ~y : y)} + {{WIDTH{1'b0}}, sub | cin};

  // A set top remainder bit means the shifted remainder already exceeds any divisor
  assign no_borrow = cout_c | acc_hi[WIDTH-1];

  always_comb begin
    nxt_hi_c = acc_hi;
    nxt_lo_c = acc_lo;
    case (state)
      ST_RUN: begin
        if (is_div) begin
          nxt_hi_c = no_borrow ? sum_c : rem_shift;
          nxt_lo_c = {acc_lo[WIDTH-2:0], no_borrow};
        end else begin
          nxt_hi_c = {cout_c, sum_c[WIDTH-1:1]};
          nxt_lo_c = {sum_c[0], acc_lo[WIDTH-1:1]};
        end
      end
      ST_FIX_LO: nxt_lo_c = neg_lo ? sum_c : acc_lo;
      ST_FIX_HI: nxt_hi_c = neg_hi ? sum_c : acc_hi;
      default: ;
    endcase
  end

endmodule

// File: rtl/muldiv_seq.sv
// Multi-cycle MULT/MULTU/DIV/DIVU sequencer writing HI/LO via a valid/ready handshake.
// Optional MULDIV_CYCLE_CNT_EN adds cnt_out, a free-running count of busy work cycles.
module muldiv_seq
  import muldiv_pkg::*;
(
  input  logic        clk_in,
  input  logic        rst_n_in,
  muldiv_if.slave     bus
`ifdef MULDIV_CYCLE_CNT_EN
  ,
  output logic [31:0] cnt_out
`endif
);

  state_e           state_q, state_d;
  req_t             req_q;
  logic [WIDTH-1:0] mag_a_q, mag_b_q, acc_hi_q, acc_lo_q;
  logic [CNT_W-1:0] cnt_q;
  logic             carry_q;
  logic             ready_q, busy_q, done_q, div0_q, div0_d;
  logic [WIDTH-1:0] hi_q, lo_q, hi_d, lo_d;

  logic             accept_c, div0_req_c, is_div_c, is_signed_c, neg_lo_c, neg_hi_c;
  logic [WIDTH-1:0] opnd_c, sum_c, nxt_hi_c, nxt_lo_c;
  logic             cout_c;

  assign accept_c    = bus.start_valid_in && ready_q;
  assign div0_req_c  = ((op_e'(bus.op_in) == OP_DIV) || (op_e'(bus.op_in) == OP_DIVU)) &&
                       (bus.b_in == '0);
  assign is_div_c    = (req_q.op == OP_DIV) || (req_q.op == OP_DIVU);
  assign is_signed_c = (req_q.op == OP_MULT) || (req_q.op == OP_DIV);
  assign neg_lo_c    = is_signed_c && (req_q.a[WIDTH-1] ^ req_q.b[WIDTH-1]);
  // Remainder takes the dividend's sign; the product's upper half follows the product sign
  assign neg_hi_c    = is_signed_c && (is_div_c ? req_q.a[WIDTH-1]
                                                : (req_q.a[WIDTH-1] ^ req_q.b[WIDTH-1]));
  assign opnd_c      = (state_q == ST_PREP_B) ? req_q.b : req_q.a;

  muldiv_step u_step (
    .state     (state_q),
    .is_div    (is_div_c),
    .opnd      (opnd_c),
    .mag_b     (mag_b_q),
    .acc_hi    (acc_hi_q),
    .acc_lo    (acc_lo_q),
    .neg_lo    (neg_lo_c),
    .neg_hi    (neg_hi_c),
    .fix_carry (carry_q),
    .sum_c     (sum_c),
    .cout_c    (cout_c),
    .nxt_hi_c  (nxt_hi_c),
    .nxt_lo_c  (nxt_lo_c)
  );

  // Next state and next registered result
  always_comb begin
    state_d = state_q;
    hi_d    = '0;
    lo_d    = '0;
    div0_d  = 1'b0;
    case (state_q)
      ST_IDLE:   if (accept_c) state_d = div0_req_c ? ST_DONE : ST_PREP_A;
      ST_PREP_A: state_d = ST_PREP_B;
      ST_PREP_B: state_d = ST_RUN;
      ST_RUN:    if (cnt_q == CNT_W'(ITERS - 1)) state_d = ST_FIX_LO;
      ST_FIX_LO: state_d = ST_FIX_HI;
      ST_FIX_HI: state_d = ST_DONE;
      ST_DONE:   if (bus.done_ready_in) state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
    if (bus.flush_in && (state_q != ST_IDLE)) state_d = ST_IDLE;
    if (state_d == ST_DONE) begin
      case (state_q)
        ST_IDLE: begin
          hi_d   = bus.a_in;
          lo_d   = DIV0_QUOT;
          div0_d = 1'b1;
        end
        ST_FIX_HI: begin
          hi_d = nxt_hi_c;
          lo_d = acc_lo_q;
        end
        default: begin
          hi_d   = hi_q;
          lo_d   = lo_q;
          div0_d = div0_q;
        end
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q <= ST_IDLE;
      ready_q <= 1'b1;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      hi_q    <= '0;
      lo_q    <= '0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      ready_q <= (state_d == ST_IDLE);
      busy_q  <= (state_d != ST_IDLE);
      done_q  <= (state_d == ST_DONE);
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      div0_q  <= div0_d;
    end
  end

  // Datapath registers advance with the phase
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      req_q    <= '0;
      mag_a_q  <= '0;
      mag_b_q  <= '0;
      acc_hi_q <= '0;
      acc_lo_q <= '0;
      cnt_q    <= '0;
      carry_q  <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept_c) begin
            req_q.op <= op_e'(bus.op_in);
            req_q.a  <= bus.a_in;
            req_q.b  <= bus.b_in;
          end
        end
        ST_PREP_A: mag_a_q <= (is_signed_c && req_q.a[WIDTH-1]) ? sum_c : req_q.a;
        ST_PREP_B: begin
          mag_b_q  <= (is_signed_c && req_q.b[WIDTH-1]) ? sum_c : req_q.b;
          acc_hi_q <= '0;
          acc_lo_q <= mag_a_q;
          cnt_q    <= '0;
        end
        ST_RUN: begin
          acc_hi_q <= nxt_hi_c;
          acc_lo_q <= nxt_lo_c;
          cnt_q    <= cnt_q + CNT_W'(1);
        end
        ST_FIX_LO: begin
          acc_lo_q <= nxt_lo_c;
          carry_q  <= cout_c;
        end
        ST_FIX_HI: acc_hi_q <= nxt_hi_c;
        default: ;
      endcase
    end
  end

  assign bus.start_ready_out = ready_q;
  assign bus.busy_out        = busy_q;
  assign bus.done_valid_out  = done_q;
  assign bus.hi_out          = hi_q;
  assign bus.lo_out          = lo_q;
  assign bus.div0_out        = div0_q;

`ifdef MULDIV_CYCLE_CNT_EN
  logic [31:0] cyc_q;

  // Counts working cycles; the wait in DONE is not work
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) cyc_q <= '0;
    else if (busy_q && !done_q) cyc_q <= cyc_q + 32'd1;
  end

  assign cnt_out = cyc_q;
`endif

endmodule

// File: tb/tb_muldiv_seq.sv
// Self-checking bench for muldiv_seq: directed corner cases plus random ops vs. an arithmetic model.
module tb_muldiv_seq;
  import muldiv_pkg::*;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   total = 0;
  int   bad = 0;

  muldiv_if bus ();

`ifdef MULDIV_CYCLE_CNT_EN
  logic [31:0] cnt;
  muldiv_seq dut (.clk_in(clk), .rst_n_in(rst_n), .bus(bus), .cnt_out(cnt));
`else
  muldiv_seq dut (.clk_in(clk), .rst_n_in(rst_n), .bus(bus));
`endif

  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  // Reference: plain 64-bit arithmetic, MIPS truncating division semantics
  function automatic void model(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                                output logic [31:0] hi, output logic [31:0] lo, output logic d0);
    logic signed [63:0] sp;
    logic [63:0]        up;
    logic signed [31:0] sa, sb;
    sa = a; sb = b; d0 = 1'b0;
    case (op)
      2'b00: begin sp = $signed({{32{a[31]}}, a}) * $signed({{32{b[31]}}, b}); {hi, lo} = sp; end
      2'b01: begin up = {32'd0, a} * {32'd0, b}; {hi, lo} = up; end
      default: begin
        if (b == 32'd0) begin
          hi = a; lo = 32'hFFFF_FFFF; d0 = 1'b1;
        end else if (op == 2'b10 && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
          lo = 32'h8000_0000; hi = 32'd0;
        end else if (op == 2'b10) begin
          lo = sa / sb; hi = sa % sb;
        end else begin
          lo = a / b; hi = a % b;
        end
      end
    endcase
  endfunction

  task automatic run_op(input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                        input int hold, input string tag);
    logic [31:0] ehi, elo;
    logic        ed0;
    int          n, exp_lat;
    model(op, a, b, ehi, elo, ed0);
    exp_lat = (op[1] && b == 32'd0) ? 0 : 36;
    @(negedge clk);
    chk({tag, "_ready"}, 64'(bus.start_ready_out), 64'd1);
    bus.start_valid_in = 1'b1; bus.op_in = op; bus.a_in = a; bus.b_in = b;
    @(negedge clk);
    bus.start_valid_in = 1'b0; bus.a_in = $urandom; bus.b_in = $urandom;
    n = 0;
    while (bus.done_valid_out !== 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk({tag, "_lat"}, 64'(n), 64'(exp_lat));
    chk({tag, "_hi"}, 64'(bus.hi_out), 64'(ehi));
    chk({tag, "_lo"}, 64'(bus.lo_out), 64'(elo));
    chk({tag, "_div0"}, 64'(bus.div0_out), 64'(ed0));
    for (int i = 0; i < hold; i++) begin
      bus.start_valid_in = (i % 2 == 0);
      @(negedge clk);
      chk({tag, "_hold_v"}, {bus.done_valid_out, bus.start_ready_out}, 64'b10);
      chk({tag, "_hold_d"}, {bus.hi_out, bus.lo_out}, {ehi, elo});
    end
    bus.start_valid_in = 1'b0;
    bus.done_ready_in = 1'b1;
    @(negedge clk);
    bus.done_ready_in = 1'b0;
    chk({tag, "_after"}, {bus.done_valid_out, bus.start_ready_out, bus.busy_out}, 64'b010);
  endtask

  initial begin
    logic [1:0]  rop;
    logic [31:0] ra, rb;
    int          seen;
    bus.start_valid_in = 1'b0; bus.op_in = 2'b00; bus.a_in = '0; bus.b_in = '0;
    bus.flush_in = 1'b0; bus.done_ready_in = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ready", 64'(bus.start_ready_out), 64'd1);
    chk("rst_flags", {bus.done_valid_out, bus.busy_out, bus.div0_out}, 64'd0);
    chk("rst_data", {bus.hi_out, bus.lo_out}, 64'd0);
    rst_n = 1'b1;

    run_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5, "multu_max");
`ifdef MULDIV_CYCLE_CNT_EN
    chk("cnt_one_op", 64'(cnt), 64'd36);
`endif
    run_op(2'b00, 32'hFFFF_FFFD, 32'd7, 0, "mult_neg");
    run_op(2'b10, 32'hFFFF_FFF9, 32'd2, 0, "div_neg");
    run_op(2'b11, 32'd100, 32'd0, 2, "divu_zero");
    run_op(2'b10, 32'h8000_0000, 32'hFFFF_FFFF, 0, "div_ovf");
    run_op(2'b10, 32'd7, 32'hFFFF_FFFE, 0, "div_pos_neg");

    // Flush during RUN iteration 10 drops the op
    @(negedge clk);
    bus.start_valid_in = 1'b1; bus.op_in = 2'b01; bus.a_in = 32'd12345; bus.b_in = 32'd678;
    @(negedge clk);
    bus.start_valid_in = 1'b0;
    repeat (12) @(negedge clk);
    chk("flush_busy_pre", 64'(bus.busy_out), 64'd1);
    bus.flush_in = 1'b1;
    @(negedge clk);
    bus.flush_in = 1'b0;
    chk("flush_idle", {bus.busy_out, bus.start_ready_out, bus.done_valid_out}, 64'b010);
    seen = 0;
    for (int i = 0; i < 40; i++) begin
      @(negedge clk);
      if (bus.done_valid_out === 1'b1) seen++;
    end
    chk("flush_no_done", 64'(seen), 64'd0);
    run_op(2'b01, 32'd2, 32'd3, 0, "multu_after_flush");

    for (int k = 0; k < 24; k++) begin
      rop = 2'($urandom_range(0, 3));
      ra  = ($urandom_range(0, 3) == 0) ? 32'($signed(6'($urandom))) : 32'($urandom);
      case ($urandom_range(0, 7))
        0:       rb = 32'd0;
        1:       rb = 32'hFFFF_FFFF;
        2:       rb = 32'($signed(5'($urandom)));
        default: rb = 32'($urandom);
      endcase
      run_op(rop, ra, rb, k % 3, "rand");
    end

    // Asynchronous reset mid-RUN
    @(negedge clk);
    bus.start_valid_in = 1'b1; bus.op_in = 2'b00; bus.a_in = 32'hDEAD_BEEF; bus.b_in = 32'h1234_5678;
    @(negedge clk);
    bus.start_valid_in = 1'b0;
    repeat (15) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_flags", {bus.start_ready_out, bus.busy_out, bus.done_valid_out, bus.div0_out}, 64'b1000);
    chk("arst_data", {bus.hi_out, bus.lo_out}, 64'd0);
`ifdef MULDIV_CYCLE_CNT_EN
    chk("arst_cnt", 64'(cnt), 64'd0);
`endif
    @(negedge clk);
    rst_n = 1'b1;
    run_op(2'b11, 32'hFFFF_FFFF, 32'd10, 0, "divu_after_rst");

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
